// File: rtl/bank_cmd_sequencer_if.sv
// Request/command bundle between the scheduler queue, the bank command sequencer
// and the DIMM command/address assembler.
interface bank_cmd_sequencer_if #(
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4,
  parameter int PADDR_BITS      = 64,
  parameter int BANK_GROUPS     = 4,
  parameter int BANKS_PER_GROUP = 2
);
  localparam int BG_W = $clog2(BANK_GROUPS);
  localparam int BA_W = $clog2(BANKS_PER_GROUP);

  logic                  req_valid_in;
  logic                  req_ready_out;
  logic [PADDR_BITS-1:0] req_addr_in;
  logic                  req_write_in;
  logic                  cmd_valid_out;
  logic [2:0]            cmd_out;
  logic [BG_W-1:0]       cmd_bg_out;
  logic [BA_W-1:0]       cmd_ba_out;
  logic [ROW_BITS-1:0]   cmd_row_out;
  logic [COL_BITS-1:0]   cmd_col_out;
  logic                  done_out;
  logic [15:0]           row_hit_count_out;

  modport master (
    output req_valid_in, req_addr_in, req_write_in,
    input  req_ready_out, cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out,
           cmd_row_out, cmd_col_out, done_out, row_hit_count_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_write_in,
    output req_ready_out, cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out,
           cmd_row_out, cmd_col_out, done_out, row_hit_count_out
  );
endinterface

// File: rtl/bank_cmd_sequencer.sv
// Turns one memory request at a time into PRECHARGE/ACTIVATE/READ/WRITE,
// tracking the open row per bank and timing each step with a down-counter.
module bank_cmd_sequencer #(
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 64,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int CAS_LATENCY        = 22,
  parameter int BURST_LEN          = 8
) (
  input logic clk_in,
  input logic rst_in,
  bank_cmd_sequencer_if.slave bus
);
  localparam int BG_W     = $clog2(BANK_GROUPS);
  localparam int BA_W     = $clog2(BANKS_PER_GROUP);
  localparam int IDX_W    = BG_W + BA_W;
  localparam int NB       = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int ADDR_USE = COL_BITS + BA_W + BG_W + ROW_BITS;
  localparam int RD_LAT   = CAS_LATENCY + BURST_LEN;
  localparam int LAT_MAX  = (RD_LAT > ACTIVATION_LATENCY) ?
                            ((RD_LAT > PRECHARGE_LATENCY) ? RD_LAT : PRECHARGE_LATENCY) :
                            ((ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY);
  localparam int CNT_W    = $clog2(LAT_MAX + 1);

  // Counters are loaded with latency-1 on the edge that registers a command,
  // so the follow-up command/done is registered on the edge it reaches zero.
  localparam logic [CNT_W-1:0] ACT_WAIT = CNT_W'(ACTIVATION_LATENCY - 1);
  localparam logic [CNT_W-1:0] PRE_WAIT = CNT_W'(PRECHARGE_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_WAIT  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_WAIT  = CNT_W'(BURST_LEN - 1);

  localparam logic [2:0] CMD_RD  = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_PRE = 3'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_PRE, WAIT_ACT, WAIT_DATA} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        wr_q, wr_d;
  logic                        ready_q, ready_d;
  logic                        cmd_valid_q, cmd_valid_d;
  logic [2:0]                  cmd_q, cmd_d;
  logic [BG_W-1:0]             cmd_bg_q, cmd_bg_d;
  logic [BA_W-1:0]             cmd_ba_q, cmd_ba_d;
  logic [ROW_BITS-1:0]         cmd_row_q, cmd_row_d;
  logic [COL_BITS-1:0]         cmd_col_q, cmd_col_d;
  logic                        done_q, done_d;
  logic [15:0]                 hit_q, hit_d;
  logic [NB-1:0]               open_q, open_d;
  logic [NB-1:0][ROW_BITS-1:0] rows_q, rows_d;

  logic [COL_BITS-1:0] in_col;
  logic [BA_W-1:0]     in_ba;
  logic [BG_W-1:0]     in_bg;
  logic [ROW_BITS-1:0] in_row;
  logic [IDX_W-1:0]    in_idx;
  logic [IDX_W-1:0]    cur_idx;
  logic                unused_addr_hi;

  assign in_col  = bus.req_addr_in[0 +: COL_BITS];
  assign in_ba   = bus.req_addr_in[COL_BITS +: BA_W];
  assign in_bg   = bus.req_addr_in[COL_BITS + BA_W +: BG_W];
  assign in_row  = bus.req_addr_in[COL_BITS + BA_W + BG_W +: ROW_BITS];
  assign in_idx  = {in_bg, in_ba};
  // The command field registers double as the latched request fields.
  assign cur_idx = {cmd_bg_q, cmd_ba_q};
  assign unused_addr_hi = ^bus.req_addr_in[PADDR_BITS-1:ADDR_USE];

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    wr_d        = wr_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    cmd_bg_d    = cmd_bg_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    open_d      = open_q;
    rows_d      = rows_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_in && ready_q) begin
          wr_d        = bus.req_write_in;
          cmd_valid_d = 1'b1;
          cmd_bg_d    = in_bg;
          cmd_ba_d    = in_ba;
          cmd_row_d   = in_row;
          cmd_col_d   = in_col;
          state_d     = ISSUE;
          if (open_q[in_idx] && rows_q[in_idx] == in_row) begin
            cmd_d = bus.req_write_in ? CMD_WR : CMD_RD;
            cnt_d = bus.req_write_in ? WR_WAIT : RD_WAIT;
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          end else if (open_q[in_idx]) begin
            cmd_d          = CMD_PRE;
            cnt_d          = PRE_WAIT;
            open_d[in_idx] = 1'b0;
          end else begin
            cmd_d          = CMD_ACT;
            cnt_d          = ACT_WAIT;
            open_d[in_idx] = 1'b1;
            rows_d[in_idx] = in_row;
          end
        end
      end
      ISSUE: begin
        case (cmd_q)
          CMD_PRE: state_d = WAIT_PRE;
          CMD_ACT: state_d = WAIT_ACT;
          default: state_d = WAIT_DATA;
        endcase
      end
      WAIT_PRE: begin
        if (cnt_q == '0) begin
          cmd_valid_d     = 1'b1;
          cmd_d           = CMD_ACT;
          cnt_d           = ACT_WAIT;
          open_d[cur_idx] = 1'b1;
          rows_d[cur_idx] = cmd_row_q;
          state_d         = WAIT_ACT;
        end
      end
      WAIT_ACT: begin
        if (cnt_q == '0) begin
          cmd_valid_d = 1'b1;
          cmd_d       = wr_q ? CMD_WR : CMD_RD;
          cnt_d       = wr_q ? WR_WAIT : RD_WAIT;
          state_d     = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      hit_q       <= '0;
      open_q      <= '0;
      rows_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      ready_q     <= ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      open_q      <= open_d;
      rows_q      <= rows_d;
    end
  end

  assign bus.req_ready_out     = ready_q;
  assign bus.cmd_valid_out     = cmd_valid_q;
  assign bus.cmd_out           = cmd_q;
  assign bus.cmd_bg_out        = cmd_bg_q;
  assign bus.cmd_ba_out        = cmd_ba_q;
  assign bus.cmd_row_out       = cmd_row_q;
  assign bus.cmd_col_out       = cmd_col_q;
  assign bus.done_out          = done_q;
  assign bus.row_hit_count_out = hit_q;
endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Scoreboard bench: a bank-state model predicts command/done cycles at each
// handshake; a negedge monitor pops and compares whatever the DUT presents.
module tb_bank_cmd_sequencer;
  localparam int ROW_BITS = 8, COL_BITS = 4, PADDR_BITS = 64;
  localparam int BANK_GROUPS = 4, BANKS_PER_GROUP = 2;
  localparam int T_ACT = 8, T_PRE = 5, T_CAS = 22, T_BURST = 8;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    int         bg;
    int         ba;
    int         row;
    int         col;
  } ev_t;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ev_t  cq[$];
  int   dq[$];
  ev_t  e;
  int   m_open[8];
  int   m_row[8];
  int   m_hits = 0;

  bank_cmd_sequencer_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PADDR_BITS(PADDR_BITS),
    .BANK_GROUPS(BANK_GROUPS), .BANKS_PER_GROUP(BANKS_PER_GROUP)) bus ();

  bank_cmd_sequencer #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PADDR_BITS(PADDR_BITS),
    .BANK_GROUPS(BANK_GROUPS), .BANKS_PER_GROUP(BANKS_PER_GROUP),
    .ACTIVATION_LATENCY(T_ACT), .PRECHARGE_LATENCY(T_PRE),
    .CAS_LATENCY(T_CAS), .BURST_LEN(T_BURST)) dut (
    .clk_in(clk), .rst_in(rst_in), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
    m_hits = 0;
    cq.delete();
    dq.delete();
  endfunction

  // Predict the command sequence for a request accepted at cycle t.
  function automatic int model_accept(logic [63:0] a, bit w, int t);
    int col, ba, bg, row, idx, rw_cyc;
    logic [2:0] rw;
    col = int'(a % 16);
    ba  = int'((a / 16) % 2);
    bg  = int'((a / 32) % 4);
    row = int'((a / 128) % 256);
    idx = bg * BANKS_PER_GROUP + ba;
    rw  = w ? 3'd1 : 3'd0;
    if (m_open[idx] != 0 && m_row[idx] == row) begin
      rw_cyc = t + 1;
      if (m_hits < 65535) m_hits++;
    end else if (m_open[idx] != 0) begin
      cq.push_back('{t + 1, 3'd3, bg, ba, row, col});
      cq.push_back('{t + 1 + T_PRE, 3'd2, bg, ba, row, col});
      rw_cyc = t + 1 + T_PRE + T_ACT;
    end else begin
      cq.push_back('{t + 1, 3'd2, bg, ba, row, col});
      rw_cyc = t + 1 + T_ACT;
    end
    m_open[idx] = 1;
    m_row[idx]  = row;
    cq.push_back('{rw_cyc, rw, bg, ba, row, col});
    dq.push_back(rw_cyc + (w ? T_BURST : T_CAS + T_BURST));
    return dq[$];
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst_in) begin
      chk("ready", bus.req_ready_out, (dq.size() == 0 || dq[0] == cyc) ? 1 : 0);
      chk("hit_count", bus.row_hit_count_out, m_hits);
      if (bus.cmd_valid_out) begin
        if (cq.size() == 0) chk("cmd_unexpected_queue_depth", cq.size(), 1);
        else begin
          e = cq.pop_front();
          chk("cmd_cycle", cyc, e.cyc);
          chk("cmd_code", bus.cmd_out, e.cmd);
          chk("cmd_bg", bus.cmd_bg_out, e.bg);
          chk("cmd_ba", bus.cmd_ba_out, e.ba);
          if (e.cmd == 3'd2) chk("cmd_row", bus.cmd_row_out, e.row);
          if (e.cmd <= 3'd1) chk("cmd_col", bus.cmd_col_out, e.col);
        end
      end else if (cq.size() != 0 && cq[0].cyc <= cyc) begin
        chk("cmd_missing_valid", bus.cmd_valid_out, 1);
        void'(cq.pop_front());
      end
      if (bus.done_out) begin
        if (dq.size() == 0) chk("done_unexpected_queue_depth", dq.size(), 1);
        else chk("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        chk("done_missing", bus.done_out, 1);
        void'(dq.pop_front());
      end
    end
  end

  task automatic check_reset_values(string tag);
    chk({tag, "_ready"}, bus.req_ready_out, 1);
    chk({tag, "_cmd_valid"}, bus.cmd_valid_out, 0);
    chk({tag, "_cmd"}, bus.cmd_out, 0);
    chk({tag, "_bg"}, bus.cmd_bg_out, 0);
    chk({tag, "_ba"}, bus.cmd_ba_out, 0);
    chk({tag, "_row"}, bus.cmd_row_out, 0);
    chk({tag, "_col"}, bus.cmd_col_out, 0);
    chk({tag, "_done"}, bus.done_out, 0);
    chk({tag, "_hits"}, bus.row_hit_count_out, 0);
  endtask

  // Present one request and hold it until accepted.
  task automatic send(input logic [63:0] a, input bit w);
    int guard = 0;
    bit took = 0;
    int t;
    int d;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1; bus.req_addr_in = a; bus.req_write_in = w;
    while (!took && guard < 200) begin
      @(negedge clk);
      if (bus.req_ready_out) begin took = 1; t = cyc; end
      else guard++;
    end
    if (took) begin #1; d = model_accept(a, w, t); end
    else chk("send_accept_timeout", guard, 0);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    a[14:7] = 8'($urandom_range(0, 3));
    return a;
  endfunction

  // Random traffic; in hold mode valid stays high and the address churns while busy.
  task automatic run_reqs(input int n, input bit hold);
    int acc = 0, iter = 0, prev_done = 0, t;
    bit have_prev = 0, hs;
    logic [63:0] a;
    bit w;
    while (acc < n && iter < n * 60 + 200) begin
      @(posedge clk); #1;
      a = rand_addr(); w = 1'($urandom());
      bus.req_valid_in = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus.req_addr_in = a; bus.req_write_in = w;
      @(negedge clk);
      hs = bus.req_valid_in && bus.req_ready_out;
      t = cyc;
      if (hs) begin
        #1;
        if (hold && have_prev) chk("b2b_accept_on_done", t, prev_done);
        prev_done = model_accept(a, w, t);
        have_prev = 1;
        acc++;
      end
      iter++;
    end
    if (acc < n) chk("run_reqs_accepted", acc, n);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
  endtask

  initial begin
    bus.req_valid_in = 1'b0; bus.req_addr_in = '0; bus.req_write_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    mon_en = 1'b1;

    send(64'h085, 1'b0);   // closed: ACT row 1, READ col 5
    send(64'h086, 1'b1);   // hit: WRITE col 6
    send(64'h105, 1'b0);   // conflict: PRE, ACT row 2, READ
    send(64'h095, 1'b0);   // other bank, closed
    send(64'h105, 1'b0);   // row 2 still open in bank 0

    send(64'h0C5, 1'b0);   // closed bank -> WAIT_ACT, then abort
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b1;
    model_reset();
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    check_reset_values("abort");
    send(64'h0C5, 1'b0);   // table cleared: ACT again
    send(64'h085, 1'b0);

    run_reqs(40, 1'b1);
    run_reqs(40, 1'b0);

    for (int i = 0; i < 200 && (cq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
    chk("drain_cmd_queue", cq.size(), 0);
    chk("drain_done_queue", dq.size(), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
